change_dispenser: RTL and testbench

Payout engine on the output side of the vending machine. It accepts a change or refund amount from the vending controller and breaks it into coins, largest denomination first. Coins are issued one at a time to the coin hopper over a valid/ready handshake. The block skips denominations whose hopper tube is empty, reports any unpaid remainder, and aborts if the hopper jams.

---
 rtl/change_dispenser.sv | 113 +++++++++++
 tb/tb_change_dispenser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a payout into coins, largest first, and issues them to the hopper one at a time.
// Empty tubes are skipped, any unpaid remainder is reported, and a hopper that never answers is declared jammed.
module change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int VAL1    = 5,
    parameter int VAL2    = 10,
    parameter int VAL3    = 25,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             refund_mode,
    input  logic [2:0]       tube_empty,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_code,
    output logic             busy,
    output logic             done,
    output logic             shortfall,
    output logic             jam,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] coins_issued,
    output logic             refund_tag
);
    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    localparam longint MAXV = (longint'(1) << AMT_W) - 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t state, state_n;
    logic [AMT_W-1:0] rem, pval;
    logic [AMT_W-1:0] v1, v2, v3;
    logic [CNT_W-1:0] cnt;
    logic [WW-1:0] wcnt;
    logic [1:0] code, pick;
    logic e1, e2, e3, timeout;

    // a value that does not fit the datapath can never be paid out
    assign v1 = AMT_W'(VAL1);
    assign v2 = AMT_W'(VAL2);
    assign v3 = AMT_W'(VAL3);
    assign e1 = (longint'(VAL1) <= MAXV) && !tube_empty[0] && (v1 <= rem);
    assign e2 = (longint'(VAL2) <= MAXV) && !tube_empty[1] && (v2 <= rem);
    assign e3 = (longint'(VAL3) <= MAXV) && !tube_empty[2] && (v3 <= rem);
    assign pick = e3 ? 2'b11 : e2 ? 2'b10 : e1 ? 2'b01 : 2'b00;
    assign pval = (code == 2'b11) ? v3 : (code == 2'b10) ? v2 : v1;
    assign timeout = (wcnt == WW'(TIMEOUT - 1));

    assign coin_valid   = (state == ISSUE);
    assign coin_code    = (state == ISSUE) ? code : 2'b00;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign remaining    = rem;
    assign coins_issued = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SELECT : IDLE;
            SELECT:  state_n = (rem == '0 || pick == 2'b00) ? DONE : ISSUE;
            ISSUE:   state_n = coin_ready ? SELECT : timeout ? DONE : ISSUE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem        <= '0;
            cnt        <= '0;
            wcnt       <= '0;
            code       <= 2'b00;
            shortfall  <= 1'b0;
            jam        <= 1'b0;
            refund_tag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rem        <= amount;
                    refund_tag <= refund_mode;
                    cnt        <= '0;
                    shortfall  <= 1'b0;
                    jam        <= 1'b0;
                end
                SELECT: begin
                    code <= pick;
                    wcnt <= '0;
                    if (rem != '0 && pick == 2'b00)
                        shortfall <= 1'b1;
                end
                ISSUE: begin
                    if (coin_ready) begin
                        rem <= rem - pval;
                        cnt <= (&cnt) ? cnt : cnt + CNT_W'(1);
                    end else if (timeout)
                        jam <= 1'b1;
                    else
                        wcnt <= wcnt + WW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized payouts checked every cycle against a greedy payout model.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] amount = '0;
    logic       refund_mode = 1'b0;
    logic [2:0] tube_empty = '0;
    logic       coin_ready = 1'b0;
    logic       coin_valid, busy, done, shortfall, jam, refund_tag;
    logic [1:0] coin_code;
    logic [7:0] remaining;
    logic [5:0] coins_issued;

    int vectors = 0;
    int miscompares = 0;
    int rmode = 0;
    int vc = 0;

    int m_q[$];
    int log_q[$];
    int m_rem = 0, m_cnt = 0, m_wait = 0;
    bit m_busy = 0, m_jam = 0, m_short = 0, m_tag = 0;

    change_dispenser #(.TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .amount(amount),
        .refund_mode(refund_mode), .tube_empty(tube_empty), .coin_ready(coin_ready),
        .coin_valid(coin_valid), .coin_code(coin_code), .busy(busy), .done(done),
        .shortfall(shortfall), .jam(jam), .remaining(remaining),
        .coins_issued(coins_issued), .refund_tag(refund_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int val(input int c);
        return c == 3 ? 25 : c == 2 ? 10 : c == 1 ? 5 : 0;
    endfunction

    // largest coin whose tube is stocked and whose value still fits
    function automatic int next_code(input int r, input logic [2:0] te);
        for (int c = 3; c >= 1; c--)
            if (!te[c-1] && val(c) <= r) return c;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("reset_outs", int'({coin_valid, coin_code, busy, done, shortfall, jam,
                                    remaining, coins_issued, refund_tag}), 0);
            m_q.delete();
            m_busy = 0; m_jam = 0; m_short = 0; m_tag = 0;
            m_rem = 0; m_cnt = 0; m_wait = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("remaining", remaining, m_rem);
            chk("coins_issued", coins_issued, m_cnt > 63 ? 63 : m_cnt);
            chk("refund_tag", refund_tag, m_tag);
            if (m_jam) chk("coin_after_jam", coin_valid, 0);
            else if (coin_valid) begin
                if (m_q.size() == 0) chk("unexpected_coin", coin_valid, 0);
                else begin
                    chk("coin_code", coin_code, m_q[0]);
                    if (coin_ready) begin
                        log_q.push_back(int'(coin_code));
                        m_rem -= val(m_q[0]);
                        void'(m_q.pop_front());
                        m_cnt++;
                        m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == 8) m_jam = 1;
                    end
                end
            end
            if (done) begin
                if (!m_jam) chk("queue_drained", m_q.size(), 0);
                m_short = !m_jam && m_rem != 0;
                chk("done_code", coin_code, 0);
                chk("done_shortfall", shortfall, m_short);
                chk("done_jam", jam, m_jam);
                m_busy = 0;
            end else if (!busy) begin
                chk("held_shortfall", shortfall, m_short);
                chk("held_jam", jam, m_jam);
                chk("idle_code", coin_code, 0);
                if (start) begin
                    int r;
                    m_busy = 1; m_jam = 0; m_short = 0; m_wait = 0; m_cnt = 0;
                    m_rem = amount; m_tag = refund_mode;
                    m_q.delete(); log_q.delete();
                    r = amount;
                    while (next_code(r, tube_empty) != 0) begin
                        m_q.push_back(next_code(r, tube_empty));
                        r -= val(next_code(r, tube_empty));
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        vc = coin_valid ? vc + 1 : 0;
        coin_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom % 4 != 0) :
                     rmode == 2 ? 1'b0 : (vc >= 4);
    end

    task automatic pay(input int amt, input bit rm, input logic [2:0] te, input int mode, output int lat);
        int n;
        rmode = mode;
        n = 0;
        while (busy && n < 3000) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        start = 1; amount = 8'(amt); refund_mode = rm; tube_empty = te;
        lat = 0;
        do begin @(posedge clk); #1; start = 0; lat++; end while (!done && lat < 3000);
        chk("done_seen", done, 1);
    endtask

    initial begin
        int lat, n, r;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, r, mode;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        pay(40, 0, 3'b000, 0, lat);
        chk("t1_latency", lat, 8);
        chk("t1_ncoins", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_code0", log_q[0], 3);
            chk("t1_code1", log_q[1], 2);
            chk("t1_code2", log_q[2], 1);
        end
        chk("t1_remaining", remaining, 0);
        chk("t1_coins", coins_issued, 3);
        chk("t1_short", shortfall, 0);
        chk("t1_jam", jam, 0);
        chk("t1_tag", refund_tag, 0);

        pay(30, 0, 3'b100, 0, lat);
        chk("t2_ncoins", log_q.size(), 3);
        if (log_q.size() == 3) chk("t2_codes", log_q[0] + log_q[1] * 4 + log_q[2] * 16, 42);
        chk("t2_remaining", remaining, 0);
        chk("t2_coins", coins_issued, 3);

        pay(7, 0, 3'b000, 0, lat);
        chk("t3_short", shortfall, 1);
        chk("t3_remaining", remaining, 2);
        chk("t3_coins", coins_issued, 1);
        if (log_q.size() == 1) chk("t3_code", log_q[0], 1);

        pay(25, 1, 3'b000, 3, lat);
        chk("t4_latency", lat, 7);
        chk("t4_remaining", remaining, 0);
        chk("t4_coins", coins_issued, 1);
        chk("t4_tag", refund_tag, 1);

        rmode = 2;
        @(posedge clk); #1;
        start = 1; amount = 25; refund_mode = 0; tube_empty = 3'b000;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            start = (lat == 4);
            amount = (lat == 4) ? 8'd99 : 8'd25;
        end while (!done && lat < 100);
        start = 0;
        chk("t5_latency", lat, 10);
        chk("t5_jam", jam, 1);
        chk("t5_remaining", remaining, 25);
        chk("t5_coins", coins_issued, 0);
        chk("t5_short", shortfall, 0);

        @(posedge clk); #1;
        start = 1; amount = 25;
        n = 0;
        do begin @(posedge clk); #1; start = 0; n++; end while (!coin_valid && n < 20);
        chk("t6_issue_reached", coin_valid, 1);
        #2 reset_n = 0;
        #1;
        chk("t6_async_valid", coin_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_rem", remaining, 0);
        @(posedge clk); #1 reset_n = 1;
        pay(0, 0, 3'b000, 0, lat);
        chk("t6_latency", lat, 2);
        chk("t6_short", shortfall, 0);

        for (int i = 0; i < 40; i++) begin
            int amt;
            logic [2:0] te;
            amt = $urandom_range(0, 120);
            te = 3'($urandom);
            mode = ($urandom % 3 == 0) ? 3 : int'($urandom % 2);
            pay(amt, 1'($urandom), te, mode, lat);
            if (mode == 0) begin
                n = 0; r = amt;
                while (next_code(r, te) != 0) begin r -= val(next_code(r, te)); n++; end
                chk("rand_latency", lat, 2 + 2 * n);
            end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
